dma_rd_skid: RTL and testbench
==============================

Name: dma_rd_skid

Overview:
- Two-entry skid buffer between the AXI4 read-data channel (R) and the DMA's enable-loaded data registers.
- Accepts beats on a valid/ready slave port and presents them on a registered master port.
- Drives the downstream register load enable (ld_en) and the clock-gate qualifier (clk_gen), so the storage stage loads exactly one beat per handshake and its clock can stop while the buffer is idle.

Parameters:
- DW, 32, data width of one beat
- CW, 8, width of beat_cnt
- IDLE_CYC, 4, consecutive idle cycles before clk_gen drops (used only with the optional feature)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous reset, active-low
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream ready, registered
- s_data  in  DW  upstream beat data
- s_last  in  1  upstream last beat of burst
- m_valid  out  1  downstream beat valid, registered
- m_ready  in  1  downstream ready
- m_data  out  DW  downstream beat data, registered
- m_last  out  1  downstream last flag, registered
- ld_en  out  1  load enable to the downstream register, equal to m_valid & m_ready (combinational)
- clk_gen  out  1  clock-gate qualifier for the downstream register; ANDed with clk there
- beat_cnt  out  CW  beats accepted downstream in the current burst
- pkt_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (asynchronous, resetn=0), all outputs take these values:
  - s_ready=0, m_valid=0, m_data=0, m_last=0
  - beat_cnt=0, pkt_done=0, clk_gen=1
  - state=EMPTY
- After resetn rises, s_ready=1 on the first posedge.
- Handshakes:
  - in = s_valid & s_ready
  - out = m_valid & m_ready
  - m_valid, m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - m_valid never drops without out.
- State machine. Main register drives the m_* outputs; skid register holds data + last.
  - EMPTY (m_valid=0):
    - in: main<=s_*, go to BUSY.
  - BUSY (main full, skid empty):
    - in & out: main<=s_*, stay.
    - in only: skid<=s_*, go to FULL.
    - out only: go to EMPTY.
    - neither: stay.
  - FULL (both full):
    - out: main<=skid, go to BUSY.
    - no out: stay.
- s_ready is registered: next value = (next_state != FULL). No combinational path from m_ready to s_ready.
- Latency: 1 cycle from in to m_valid when EMPTY. Full throughput, one beat per cycle, with m_ready held at 1.
- Ordering: strict FIFO order. The last flag travels with its beat.
- beat_cnt:
  - ld_en & m_last: clears to 0.
  - ld_en & ~m_last: increments.
  - Saturates at 2^CW-1 and does not wrap.
- pkt_done = 1 for exactly one cycle after the cycle in which ld_en & m_last occurs.
- Simultaneous events:
  - Simultaneous in & out in BUSY keeps occupancy constant.
  - In FULL, s_valid is ignored because s_ready=0.
- Reset mid-burst: buffered beats are discarded and beat_cnt is cleared. No partial pkt_done is issued.

Optional Feature:
- Macro: DMA_RD_SKID_CLK_GATE_EN.
- With the macro defined:
  - An idle counter increments each cycle with state=EMPTY and s_valid=0, saturating at IDLE_CYC. Any other cycle clears it.
  - gate_req = ~(idle_cnt==IDLE_CYC) | s_valid.
  - clk_gen is gate_req captured on the negedge of clk, so it changes only while clk is low. This keeps clk & clk_gen glitch-free at the downstream register.
  - clk_gen resets to 1.
- Without the macro: clk_gen is tied to 1 and no idle counter exists.

Decomposition:
- Shared package dma_pkg holds:
  - State encoding typedef skid_state_t {EMPTY, BUSY, FULL}
  - Default widths DMA_DW=32 and DMA_CW=8
- Sub-module: dma_clk_gate_ctrl, containing the idle counter and the negedge clk_gen flop. It is instantiated only under DMA_RD_SKID_CLK_GATE_EN.

Test Plan:
- Reset, then 1 beat s_data=0xA5, s_last=1, m_ready=1 -> m_valid=1 one cycle later with m_data=0xA5; ld_en=1; pkt_done pulses the next cycle; beat_cnt returns to 0.
- 8-beat burst 0x0..0x7, m_ready=1 constant -> 8 consecutive m_valid cycles; s_ready stays 1; beat_cnt reads 0..7 before each accept.
- m_ready=0 while sending 3 beats -> 2 beats accepted; s_ready=0 from the cycle after the second in; m_data holds the first beat. Release m_ready -> order 1,2,3 preserved.
- Alternating m_ready 1/0 with a random s_valid stream of 64 beats -> no loss or duplication; m_* stable under backpressure.
- Assert resetn=0 mid-burst with FULL state -> next cycle m_valid=0, s_ready=0, beat_cnt=0; no pkt_done.
- With DMA_RD_SKID_CLK_GATE_EN, leave the buffer idle for 4 cycles -> clk_gen falls at a negedge. s_valid=1 -> clk_gen rises at the following negedge. Check there is never a clk_gen edge while clk=1.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read-data path: skid buffer state encoding
// and default beat/counter widths.
package dma_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   localparam int DMA_DW = 32;
   localparam int DMA_CW = 8;

endpackage

// File: rtl/dma_clk_gate_ctrl.sv
// Clock-gate qualifier for the downstream data register. It counts
// consecutive idle cycles (buffer empty and no incoming beat). It drops
// clk_gen once the count reaches IDLE_CYC.
// clk_gen is launched from the falling edge, so it only changes while clk is
// low and the downstream AND gate sees no glitch.
module dma_clk_gate_ctrl #(
   parameter int IDLE_CYC = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic buf_empty,
   input  logic s_valid,
   output logic clk_gen
);

   localparam int IW = $clog2(IDLE_CYC + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC);

   logic [IW-1:0] idle_cnt_reg;
   logic          gate_req;
   logic          clk_gen_reg;

   // Idle counter: saturates at IDLE_CYC, any activity clears it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idle_cnt_reg <= '0;
      end else if (buf_empty && !s_valid) begin
         if (idle_cnt_reg != IDLE_MAX) begin
            idle_cnt_reg <= idle_cnt_reg + IW'(1);
         end
      end else begin
         idle_cnt_reg <= '0;
      end
   end

   // An incoming beat re-enables the clock immediately, without waiting for the counter
   assign gate_req = (idle_cnt_reg != IDLE_MAX) | s_valid;

   // Capture the request on the falling edge so clk_gen only moves while clk is low
   always_ff @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_gen_reg <= 1'b1;
      end else begin
         clk_gen_reg <= gate_req;
      end
   end

   assign clk_gen = clk_gen_reg;

endmodule

// File: rtl/dma_rd_skid.sv
// Two-entry skid buffer between the AXI4 R channel and the DMA's
// enable-loaded data registers. The main register drives m_*, and the skid
// register catches the beat that arrives while downstream stalls.
// s_ready is registered, so m_ready has no combinational path to s_ready.
// Optional feature: define DMA_RD_SKID_CLK_GATE_EN to enable idle-based
// gating of clk_gen. Otherwise clk_gen is tied high.
module dma_rd_skid
   import dma_pkg::*;
#(
   parameter int DW       = DMA_DW,
   parameter int CW       = DMA_CW,
   parameter int IDLE_CYC = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   output logic          ld_en,
   output logic          clk_gen,
   output logic [CW-1:0] beat_cnt,
   output logic          pkt_done
);

   skid_state_t   state_reg, state_next;
   logic [DW-1:0] main_data_reg, main_data_next;
   logic          main_last_reg, main_last_next;
   logic [DW-1:0] skid_data_reg, skid_data_next;
   logic          skid_last_reg, skid_last_next;
   logic          m_valid_reg, m_valid_next;
   logic          s_ready_reg, s_ready_next;
   logic [CW-1:0] beat_cnt_reg, beat_cnt_next;
   logic          pkt_done_reg, pkt_done_next;
   logic          in_hs;
   logic          out_hs;

   assign in_hs  = s_valid & s_ready_reg;
   assign out_hs = m_valid_reg & m_ready;

   // Next-state and datapath steering for the main/skid registers
   always_comb begin
      state_next     = state_reg;
      main_data_next = main_data_reg;
      main_last_next = main_last_reg;
      skid_data_next = skid_data_reg;
      skid_last_next = skid_last_reg;
      case (state_reg)
         EMPTY: begin
            if (in_hs) begin
               main_data_next = s_data;
               main_last_next = s_last;
               state_next     = BUSY;
            end
         end
         BUSY: begin
            if (in_hs && out_hs) begin
               main_data_next = s_data;
               main_last_next = s_last;
            end else if (in_hs) begin
               skid_data_next = s_data;
               skid_last_next = s_last;
               state_next     = FULL;
            end else if (out_hs) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_hs) begin
               main_data_next = skid_data_reg;
               main_last_next = skid_last_reg;
               state_next     = BUSY;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
      m_valid_next = (state_next != EMPTY);
      s_ready_next = (state_next != FULL);
   end

   // Per-burst beat counter: last beat clears it, otherwise count up and saturate
   always_comb begin
      beat_cnt_next = beat_cnt_reg;
      pkt_done_next = out_hs & main_last_reg;
      if (out_hs) begin
         if (main_last_reg) begin
            beat_cnt_next = '0;
         end else if (beat_cnt_reg != {CW{1'b1}}) begin
            beat_cnt_next = beat_cnt_reg + CW'(1);
         end
      end
   end

   // State, storage and status registers; reset discards any buffered beats
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= EMPTY;
         main_data_reg <= '0;
         main_last_reg <= 1'b0;
         skid_data_reg <= '0;
         skid_last_reg <= 1'b0;
         m_valid_reg   <= 1'b0;
         s_ready_reg   <= 1'b0;
         beat_cnt_reg  <= '0;
         pkt_done_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         main_data_reg <= main_data_next;
         main_last_reg <= main_last_next;
         skid_data_reg <= skid_data_next;
         skid_last_reg <= skid_last_next;
         m_valid_reg   <= m_valid_next;
         s_ready_reg   <= s_ready_next;
         beat_cnt_reg  <= beat_cnt_next;
         pkt_done_reg  <= pkt_done_next;
      end
   end

   assign s_ready  = s_ready_reg;
   assign m_valid  = m_valid_reg;
   assign m_data   = main_data_reg;
   assign m_last   = main_last_reg;
   assign ld_en    = out_hs;
   assign beat_cnt = beat_cnt_reg;
   assign pkt_done = pkt_done_reg;

`ifdef DMA_RD_SKID_CLK_GATE_EN
   dma_clk_gate_ctrl #(
      .IDLE_CYC (IDLE_CYC)
   ) u_clk_gate_ctrl (
      .clk       (clk),
      .resetn    (resetn),
      .buf_empty (state_reg == EMPTY),
      .s_valid   (s_valid),
      .clk_gen   (clk_gen)
   );
`else
   assign clk_gen = 1'b1;
`endif

endmodule

// File: tb/tb_dma_rd_skid.sv
// Self-checking bench for dma_rd_skid. A queue-based model of the buffer
// contents is compared with the DUT every cycle, and directed scenarios pin
// literal values.
module tb_dma_rd_skid;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          ld_en;
   logic          clk_gen;
   logic [CW-1:0] beat_cnt;
   logic          pkt_done;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   dma_rd_skid #(.DW(DW), .CW(CW), .IDLE_CYC(4)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .ld_en    (ld_en),
      .clk_gen  (clk_gen),
      .beat_cnt (beat_cnt),
      .pkt_done (pkt_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   beat_t mq[$];
   beat_t pend_beat;
   beat_t pop_b;
   beat_t prev_beat;
   int    m_cnt;
   bit    m_pkt;
   int    m_edges;
   bit    pend_v, pend_in, pend_out, pend_sv;
   bit    prev_stall;
   bit    exp_valid, exp_ready;
   int    pushes = 0;
   int    pops   = 0;
`ifdef DMA_RD_SKID_CLK_GATE_EN
   localparam int IDLE = 4;
   int m_idle;
`endif

   // Compare process: sample just after each falling edge
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!resetn) begin
            mq.delete();
            m_cnt = 0; m_pkt = 0; m_edges = 0;
            pend_v = 0; prev_stall = 0;
`ifdef DMA_RD_SKID_CLK_GATE_EN
            m_idle = 0;
`endif
            chk("rst_s_ready",  {63'b0, s_ready},  64'd0);
            chk("rst_m_valid",  {63'b0, m_valid},  64'd0);
            chk("rst_m_data",   {32'b0, m_data},   64'd0);
            chk("rst_m_last",   {63'b0, m_last},   64'd0);
            chk("rst_beat_cnt", {56'b0, beat_cnt}, 64'd0);
            chk("rst_pkt_done", {63'b0, pkt_done}, 64'd0);
            chk("rst_clk_gen",  {63'b0, clk_gen},  64'd1);
         end else begin
            if (pend_v) begin
               m_pkt = 0;
`ifdef DMA_RD_SKID_CLK_GATE_EN
               if (mq.size() == 0 && !pend_sv) m_idle = (m_idle < IDLE) ? m_idle + 1 : IDLE;
               else m_idle = 0;
`endif
               if (pend_out) begin
                  pop_b = mq.pop_front();
                  pops++;
                  if (pop_b.l) begin
                     m_cnt = 0;
                     m_pkt = 1;
                  end else if (m_cnt < (1 << CW) - 1) begin
                     m_cnt++;
                  end
               end
               if (pend_in) begin
                  mq.push_back(pend_beat);
                  pushes++;
               end
               m_edges++;
            end
            exp_valid = (mq.size() > 0);
            exp_ready = (m_edges > 0) && (mq.size() < 2);
            chk("s_ready",  {63'b0, s_ready},  {63'b0, exp_ready});
            chk("m_valid",  {63'b0, m_valid},  {63'b0, exp_valid});
            chk("ld_en",    {63'b0, ld_en},    {63'b0, exp_valid & m_ready});
            chk("beat_cnt", {56'b0, beat_cnt}, 64'(m_cnt));
            chk("pkt_done", {63'b0, pkt_done}, {63'b0, m_pkt});
            if (exp_valid) begin
               chk("m_data", {32'b0, m_data}, {32'b0, mq[0].d});
               chk("m_last", {63'b0, m_last}, {63'b0, mq[0].l});
            end
            if (prev_stall) begin
               chk("stall_m_data", {32'b0, m_data}, {32'b0, prev_beat.d});
               chk("stall_m_last", {63'b0, m_last}, {63'b0, prev_beat.l});
            end
`ifdef DMA_RD_SKID_CLK_GATE_EN
            chk("clk_gen", {63'b0, clk_gen}, {63'b0, (m_idle != IDLE) || s_valid});
`else
            chk("clk_gen", {63'b0, clk_gen}, 64'd1);
`endif
            pend_v    = 1;
            pend_sv   = s_valid;
            pend_in   = s_valid && exp_ready;
            pend_out  = exp_valid && m_ready;
            pend_beat = '{d: s_data, l: s_last};
            prev_stall = exp_valid && !m_ready;
            if (exp_valid) prev_beat = mq[0];
         end
      end
   end

`ifdef DMA_RD_SKID_CLK_GATE_EN
   // clk_gen must only move while clk is low (reset excepted)
   always @(clk_gen) begin
      if (resetn === 1'b1) begin
         n_checks++;
         if (clk !== 1'b0) begin
            n_err++;
            $display("FAIL clk_gen_edge_while_clk_high at t=%0t: clk=%b clk_gen=%b required clk=0", $time, clk, clk_gen);
         end
      end
   end
`endif

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #2;
   endtask

   int  sent, cyc, push0;
   bit  hs, hold;

   initial begin
      resetn = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;
      repeat (3) step();
      sample();
      chk("lit_rst_s_ready", {63'b0, s_ready}, 64'd0);
      step();
      resetn = 1;
      sample();
      chk("lit_first_cycle_s_ready", {63'b0, s_ready}, 64'd0);
      step();

      // single beat 0xA5 with last
      s_valid = 1; s_data = 32'hA5; s_last = 1; m_ready = 1;
      sample();
      chk("lit_s_ready_after_reset", {63'b0, s_ready}, 64'd1);
      step();
      s_valid = 0;
      sample();
      chk("lit_single_m_valid", {63'b0, m_valid}, 64'd1);
      chk("lit_single_m_data", {32'b0, m_data}, 64'hA5);
      chk("lit_single_ld_en", {63'b0, ld_en}, 64'd1);
      chk("lit_single_pkt_pre", {63'b0, pkt_done}, 64'd0);
      step();
      sample();
      chk("lit_single_pkt_done", {63'b0, pkt_done}, 64'd1);
      chk("lit_single_beat_cnt", {56'b0, beat_cnt}, 64'd0);
      chk("lit_single_empty", {63'b0, m_valid}, 64'd0);
      step();

      // 8-beat burst at full throughput
      for (int i = 0; i < 8; i++) begin
         s_valid = 1; s_data = 32'(i); s_last = (i == 7);
         sample();
         if (i > 0) begin
            chk("lit_burst_m_data", {32'b0, m_data}, 64'(i - 1));
            chk("lit_burst_beat_cnt", {56'b0, beat_cnt}, 64'(i - 1));
            chk("lit_burst_s_ready", {63'b0, s_ready}, 64'd1);
         end
         step();
      end
      s_valid = 0;
      sample();
      chk("lit_burst_m_data7", {32'b0, m_data}, 64'd7);
      chk("lit_burst_cnt7", {56'b0, beat_cnt}, 64'd7);
      step();
      sample();
      chk("lit_burst_pkt_done", {63'b0, pkt_done}, 64'd1);
      chk("lit_burst_cnt_clr", {56'b0, beat_cnt}, 64'd0);
      step();

      // backpressure: three beats, downstream stalled
      m_ready = 0; s_valid = 1; s_data = 32'h11; s_last = 0;
      sample();
      step();
      s_data = 32'h22;
      sample();
      chk("lit_bp_first", {32'b0, m_data}, 64'h11);
      chk("lit_bp_ready1", {63'b0, s_ready}, 64'd1);
      step();
      s_data = 32'h33; s_last = 1;
      sample();
      chk("lit_bp_full_ready", {63'b0, s_ready}, 64'd0);
      chk("lit_bp_full_data", {32'b0, m_data}, 64'h11);
      step();
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("lit_bp_hold_data", {32'b0, m_data}, 64'h11);
         chk("lit_bp_hold_ready", {63'b0, s_ready}, 64'd0);
         step();
      end
      m_ready = 1;
      sample();
      chk("lit_bp_rel_data", {32'b0, m_data}, 64'h11);
      step();
      sample();
      chk("lit_bp_second", {32'b0, m_data}, 64'h22);
      chk("lit_bp_ready_back", {63'b0, s_ready}, 64'd1);
      step();
      s_valid = 0;
      sample();
      chk("lit_bp_third", {32'b0, m_data}, 64'h33);
      chk("lit_bp_third_last", {63'b0, m_last}, 64'd1);
      chk("lit_bp_cnt2", {56'b0, beat_cnt}, 64'd2);
      step();
      sample();
      chk("lit_bp_pkt_done", {63'b0, pkt_done}, 64'd1);
      step();

      // random stream of 64 beats with alternating m_ready
      push0 = pushes; sent = 0; cyc = 0; hold = 0;
      while (sent < 64 && cyc < 2000) begin
         if (!hold) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            s_last  = ($urandom_range(0, 7) == 0) || (sent == 63);
         end
         m_ready = cyc[0];
         sample();
         hs = s_valid && s_ready;
         step();
         if (hs) sent++;
         hold = s_valid && !hs;
         cyc++;
      end
      chk("rand_within_budget", {63'b0, cyc < 2000}, 64'd1);
      s_valid = 0; m_ready = 1;
      repeat (4) begin
         sample();
         step();
      end
      chk("rand_no_loss", 64'(pushes - push0), 64'd64);
      chk("rand_drained", {63'b0, m_valid}, 64'd0);

      // reset while FULL, with beat_cnt non-zero
      m_ready = 1; s_valid = 1; s_data = 32'h5A; s_last = 0;
      sample();
      step();
      s_data = 32'h5B;
      sample();
      step();
      m_ready = 0; s_data = 32'h5C; s_last = 1;
      sample();
      step();
      s_valid = 0;
      sample();
      chk("lit_prerst_full", {63'b0, s_ready}, 64'd0);
      chk("lit_prerst_cnt", {56'b0, beat_cnt}, 64'd1);
      step();
      resetn = 0;
      sample();
      chk("lit_midrst_m_valid", {63'b0, m_valid}, 64'd0);
      chk("lit_midrst_s_ready", {63'b0, s_ready}, 64'd0);
      chk("lit_midrst_cnt", {56'b0, beat_cnt}, 64'd0);
      chk("lit_midrst_pkt", {63'b0, pkt_done}, 64'd0);
      step();
      m_ready = 1;
      sample();
      chk("lit_midrst_pkt2", {63'b0, pkt_done}, 64'd0);
      step();
      resetn = 1;
      step();
      sample();
      chk("lit_postrst_ready", {63'b0, s_ready}, 64'd1);
      chk("lit_postrst_valid", {63'b0, m_valid}, 64'd0);
      step();

      // idle period, then wake up
      s_valid = 0; m_ready = 0;
      repeat (6) begin
         sample();
         step();
      end
      sample();
`ifdef DMA_RD_SKID_CLK_GATE_EN
      chk("lit_idle_clk_gen", {63'b0, clk_gen}, 64'd0);
`else
      chk("lit_idle_clk_gen", {63'b0, clk_gen}, 64'd1);
`endif
      step();
      s_valid = 1; s_data = 32'h77; s_last = 1; m_ready = 1;
      sample();
      chk("lit_wake_clk_gen", {63'b0, clk_gen}, 64'd1);
      step();
      s_valid = 0;
      repeat (8) begin
         sample();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before t=1000000");
      $fatal(1);
   end

endmodule
